// File: rtl/dec_addr_sequencer.sv
// Address sequencer driving a 4-to-16 decoder: steps from start_addr to end_addr,
// dwelling dwell+1 cycles per address, with pause/abort and single-pass or endless scan.
module dec_addr_sequencer #(
    parameter int unsigned DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               pause,
    input  logic               continuous,
    input  logic [3:0]         start_addr,
    input  logic [3:0]         end_addr,
    input  logic [DWELL_W-1:0] dwell,
    output logic               a,
    output logic               b,
    output logic               c,
    output logic               d,
    output logic               en,
    output logic               busy,
    output logic               done,
    output logic               wrap
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t             r_state;
    logic [3:0]         r_addr;
    logic [3:0]         r_start_addr;
    logic [3:0]         r_end_addr;
    logic [DWELL_W-1:0] r_dwell;
    logic [DWELL_W-1:0] r_cnt;
    logic               r_en;
    logic               r_busy;
    logic               r_done;
    logic               r_wrap;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_start_addr <= '0;
            r_end_addr   <= '0;
            r_dwell      <= '0;
            r_cnt        <= '0;
            r_en         <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_wrap       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_wrap <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !abort) begin
                        r_state      <= RUN;
                        r_addr       <= start_addr;
                        r_start_addr <= start_addr;
                        r_end_addr   <= end_addr;
                        r_dwell      <= dwell;
                        r_cnt        <= '0;
                        r_en         <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                RUN, PAUSE: begin
                    if (abort) begin
                        r_state <= IDLE;
                        r_en    <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (pause) begin
                        r_state <= PAUSE;
                    end else begin
                        // Leaving PAUSE counts this cycle, so each paused cycle adds exactly one to the dwell
                        r_state <= RUN;
                        if (r_cnt == r_dwell) begin
                            r_cnt <= '0;
                            if (r_addr != r_end_addr) begin
                                r_addr <= r_addr + 4'd1;
                            end else if (continuous) begin
                                r_addr <= r_start_addr;
                                r_wrap <= 1'b1;
                            end else begin
                                r_state <= IDLE;
                                r_done  <= 1'b1;
                                r_en    <= 1'b0;
                                r_busy  <= 1'b0;
                            end
                        end else begin
                            r_cnt <= r_cnt + DWELL_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign a    = r_addr[3];
    assign b    = r_addr[2];
    assign c    = r_addr[1];
    assign d    = r_addr[0];
    assign en   = r_en;
    assign busy = r_busy;
    assign done = r_done;
    assign wrap = r_wrap;

endmodule
